// File: rtl/sort_collect_pkg.sv
// Shared definitions for the sorter input collector: slot geometry,
// collector states and the default en pulse width.
package sort_collect_pkg;

  localparam int N_SLOTS            = 5;
  localparam int CELL_W             = 4;
  localparam int CNT_W              = 3;
  localparam int PCNT_W             = 4;
  localparam int DEF_EN_HIGH_CYCLES = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sort_input_collector.sv
// Collects five 4-bit cell codes over a valid/ready handshake into slots
// a1..a5, then raises the sorter trigger en for EN_HIGH_CYCLES cycles and
// freezes the slots until restart.
// Optional build macro FILL_TIMEOUT_EN: aborts a partial fill after
// TIMEOUT_CYCLES idle cycles and pulses timeout_err.
module sort_input_collector
  import sort_collect_pkg::*;
#(
  parameter int EN_HIGH_CYCLES = DEF_EN_HIGH_CYCLES,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CELL_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic [CELL_W-1:0] a1,
  output logic [CELL_W-1:0] a2,
  output logic [CELL_W-1:0] a3,
  output logic [CELL_W-1:0] a4,
  output logic [CELL_W-1:0] a5,
  output logic              en,
  output logic              full,
  output logic              timeout_err
);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(EN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SLOTS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_count;
  logic [PCNT_W-1:0] r_pcnt;
  logic              r_en;
  logic              r_full;
  logic [CELL_W-1:0] r_slot [N_SLOTS];
  logic              w_ready;
  logic              w_accept;
  logic              w_timeout;

  // restart wins over a same-cycle word, so ready drops while it is high
  assign w_ready  = (r_state == FILL) & ~restart;
  assign w_accept = in_valid & w_ready;

`ifdef FILL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_idle;
  logic            r_timeout_err;

  assign w_timeout = (r_state == FILL) && (r_count != '0) && !w_accept &&
                     !restart && (r_idle == TO_W'(TIMEOUT_CYCLES - 1));

  // idle counter runs only on a partial fill; any accept, restart or abort clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state != FILL || r_count == '0 || w_accept || restart || w_timeout)
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic [31:0] w_unused_timeout_cycles;

  assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign w_timeout               = 1'b0;
  assign timeout_err             = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_accept && r_count == CNT_LAST) w_next = FIRE;
      FIRE:    if (r_pcnt == PCNT_LAST)             w_next = DONE;
      DONE:    if (restart)                         w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // fill counter, en pulse counter and the registered en/full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_pcnt  <= '0;
      r_en    <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_pcnt <= '0;
          if (restart || w_timeout)
            r_count <= '0;
          else if (w_accept)
            r_count <= (r_count == CNT_LAST) ? '0 : r_count + 1'b1;
        end
        // en rises one edge after a5 is captured, so the slots settle first
        FIRE: begin
          if (r_pcnt == PCNT_LAST) begin
            r_en   <= 1'b0;
            r_full <= 1'b1;
          end else begin
            r_en   <= 1'b1;
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        DONE: begin
          if (restart) begin
            r_full  <= 1'b0;
            r_count <= '0;
          end
        end
        default: begin
          r_count <= '0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  // slot write on accept; stale slots are kept across restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++)
        if (w_accept && r_count == CNT_W'(i)) r_slot[i] <= in_data;
    end
  end

  assign in_ready = w_ready;
  assign en       = r_en;
  assign full     = r_full;
  assign a1       = r_slot[0];
  assign a2       = r_slot[1];
  assign a3       = r_slot[2];
  assign a4       = r_slot[3];
  assign a5       = r_slot[4];

endmodule

// File: tb/tb_sort_input_collector.sv
// Self-checking bench for sort_input_collector: a per-cycle vector table
// for the main fill/fire/done flow plus hand-written multi-cycle sequences.
module tb_sort_input_collector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       restart;
  logic [3:0] a1, a2, a3, a4, a5;
  logic       en;
  logic       full;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        rs;
    logic        rdy;
    logic        en;
    logic        full;
    logic [19:0] a;   // {a1,a2,a3,a4,a5}, one hex digit per slot
  } vec_t;

  vec_t vq[$];

  sort_input_collector #(
    .EN_HIGH_CYCLES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .a4         (a4),
    .a5         (a5),
    .en         (en),
    .full       (full),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] slots();
    return {a1, a2, a3, a4, a5};
  endfunction

  task automatic add(input logic v, input logic [3:0] d, input logic rs,
                     input logic rdy, input logic e, input logic f,
                     input logic [19:0] a);
    vec_t t;
    t.v = v; t.d = d; t.rs = rs; t.rdy = rdy; t.en = e; t.full = f; t.a = a;
    vq.push_back(t);
  endtask

  // present one word and wait (bounded) for it to be accepted
  task automatic send(input logic [3:0] d);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready=%0d expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    #1;
  endtask

  initial begin
    int hi_cnt, pulses, to_pulses;
    logic prev_en;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; restart = 1'b0;

    // main flow: back-to-back fill, restart in FIRE/DONE/FILL, stale slots
    add(1, 4'h3, 0, 1, 0, 0, 20'h30000);
    add(1, 4'h9, 0, 1, 0, 0, 20'h39000);
    add(1, 4'h1, 0, 1, 0, 0, 20'h39100);
    add(1, 4'hC, 0, 1, 0, 0, 20'h391C0);
    add(1, 4'h7, 0, 1, 0, 0, 20'h391C7);
    add(1, 4'h5, 0, 0, 1, 0, 20'h391C7);
    add(0, 4'h0, 1, 0, 1, 0, 20'h391C7);
    add(0, 4'h0, 0, 0, 0, 1, 20'h391C7);
    add(0, 4'h0, 0, 0, 0, 1, 20'h391C7);
    add(1, 4'h6, 1, 0, 0, 0, 20'h391C7);
    add(1, 4'h1, 0, 1, 0, 0, 20'h191C7);
    add(1, 4'h6, 1, 0, 0, 0, 20'h191C7);
    add(1, 4'h2, 0, 1, 0, 0, 20'h291C7);
    add(1, 4'h3, 0, 1, 0, 0, 20'h231C7);
    add(1, 4'h4, 0, 1, 0, 0, 20'h234C7);
    add(1, 4'h5, 0, 1, 0, 0, 20'h23457);
    add(1, 4'h6, 0, 1, 0, 0, 20'h23456);
    add(0, 4'h0, 0, 0, 1, 0, 20'h23456);
    add(0, 4'h0, 0, 0, 1, 0, 20'h23456);
    add(0, 4'h0, 0, 0, 0, 1, 20'h23456);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en, 0);
    chk("rst_full", full, 0);
    chk("rst_slots", slots(), 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = vq[i].v;
      in_data  = vq[i].d;
      restart  = vq[i].rs;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vq[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i), en, vq[i].en);
      chk($sformatf("v%0d_full", i), full, vq[i].full);
      chk($sformatf("v%0d_slots", i), slots(), vq[i].a);
    end
    in_valid = 1'b0; restart = 1'b0;

    // restart from DONE, gapped partial fill, restart, then a full fill
    do_restart();
    chk("done_restart_full", full, 0);
    chk("done_restart_ready", in_ready, 1);
    send(4'h4);
    idle(2);
    send(4'h4);
    idle(3);
    chk("gap_en", en, 0);
    chk("gap_full", full, 0);
    do_restart();
    send(4'h1); send(4'h2); send(4'h3); send(4'h4); send(4'h5);
    hi_cnt = 0; pulses = 0; prev_en = en;
    if (en) begin hi_cnt++; pulses++; end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (en) hi_cnt++;
      if (en && !prev_en) pulses++;
      prev_en = en;
    end
    chk("gap_en_cycles", hi_cnt, 2);
    chk("gap_en_pulses", pulses, 1);
    chk("gap_full_after", full, 1);
    chk("gap_slots", slots(), 20'h12345);
    chk("gap_ready_done", in_ready, 0);

    // asynchronous reset in the middle of the en pulse
    do_restart();
    send(4'h9); send(4'h8); send(4'h7); send(4'h6); send(4'h5);
    for (int c = 0; c < 5 && !en; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_fire_en_before", en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", en, 0);
    chk("async_rst_full", full, 0);
    chk("async_rst_slots", slots(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    send(4'hA);
    chk("post_rst_slots", slots(), 20'hA0000);
    send(4'hB);

    // idle mid-fill: abort with the timeout build, wait forever without it
    to_pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (timeout_err) to_pulses++;
    end
`ifdef FILL_TIMEOUT_EN
    chk("timeout_pulses", to_pulses, 1);
    send(4'h1); send(4'h2); send(4'h3); send(4'h4); send(4'h5);
    chk("timeout_refill_slots", slots(), 20'h12345);
`else
    chk("no_timeout_pulses", to_pulses, 0);
    send(4'h3); send(4'h4); send(4'h5);
    chk("no_timeout_slots", slots(), 20'hAB345);
`endif
    idle(2);
    chk("final_en", en, 1);
    idle(2);
    chk("final_full", full, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
